// File: rtl/gps_pkg.sv
// Shared definitions for the NMEA sentence parser.
//  - ASCII framing constants used by the sentence FSM
//  - FSM state encoding
//  - hex_to_nib: ASCII hex digit -> {valid, nibble}
package gps_pkg;

  localparam logic [7:0] ASCII_DOLLAR = 8'h24;
  localparam logic [7:0] ASCII_COMMA  = 8'h2C;
  localparam logic [7:0] ASCII_STAR   = 8'h2A;
  localparam logic [7:0] ASCII_CR     = 8'h0D;
  localparam logic [7:0] ASCII_LF     = 8'h0A;

  // Header is talker (2 chars) + sentence ID (3 chars)
  localparam logic [2:0] HDR_CHARS = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_FLD  = 3'd2,
    ST_CS1  = 3'd3,
    ST_CS2  = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  // Returns {1'b1, nibble} for 0-9 / A-F / a-f, otherwise 5'd0
  function automatic logic [4:0] hex_to_nib(input logic [7:0] c);
    logic [4:0] r;
    r = 5'd0;
    if (c >= 8'h30 && c <= 8'h39) begin
      r = {1'b1, c[3:0]};
    end else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) begin
      r = {1'b1, c[3:0] + 4'd9};
    end else begin
      r = 5'd0;
    end
    return r;
  endfunction

endpackage

// File: rtl/nmea_field_buf.sv
// Working field storage for one NMEA sentence.
// Ports:
//  clk, rst        clock, asynchronous active-high reset
//  clr             clears all fields, lengths, write pointer and truncation flag
//  char_en         store char_data at the current (field, char) write pointer
//  char_data       byte to store
//  field_en        a ',' was seen: advance to the next field
//  fields          flattened storage, field i char j at [(i*FIELD_CHARS+j)*8 +: 8]
//  lens            stored char count per field, LW bits each
//  nfields         fields seen so far, saturating at MAX_FIELDS
//  trunc           a char or a field did not fit
module nmea_field_buf
  import gps_pkg::*;
#(
  parameter int MAX_FIELDS  = 8,
  parameter int FIELD_CHARS = 12,
  parameter int LW          = 4,
  parameter int NW          = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              clr,
  input  logic                              char_en,
  input  logic [7:0]                        char_data,
  input  logic                              field_en,
  output logic [MAX_FIELDS*FIELD_CHARS*8-1:0] fields,
  output logic [MAX_FIELDS*LW-1:0]          lens,
  output logic [NW-1:0]                     nfields,
  output logic                              trunc
);

  localparam int FW = (MAX_FIELDS > 1) ? $clog2(MAX_FIELDS) : 1;
  localparam int CW = (FIELD_CHARS > 1) ? $clog2(FIELD_CHARS) : 1;

  logic [7:0]    mem_r [MAX_FIELDS][FIELD_CHARS];
  logic [LW-1:0] len_r [MAX_FIELDS];
  // Field index; the value MAX_FIELDS means "past the last stored field"
  logic [NW-1:0] fidx_r;
  logic          trunc_r;

  logic          fidx_in_range_s;
  logic [FW-1:0] fsel_s;
  logic [LW-1:0] cur_len_s;
  logic          char_room_s;

  // Write-pointer decode: the current field's length doubles as the char index
  always_comb begin
    fidx_in_range_s = (fidx_r < NW'(MAX_FIELDS));
    fsel_s          = fidx_r[FW-1:0];
    if (fidx_in_range_s) begin
      cur_len_s = len_r[fsel_s];
    end else begin
      cur_len_s = '0;
    end
    char_room_s = fidx_in_range_s && (cur_len_s < LW'(FIELD_CHARS));
  end

  // Field storage, lengths, write pointer and truncation flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fidx_r  <= '0;
      trunc_r <= 1'b0;
      for (int i = 0; i < MAX_FIELDS; i++) begin
        len_r[i] <= '0;
        for (int j = 0; j < FIELD_CHARS; j++) mem_r[i][j] <= 8'h00;
      end
    end else if (clr) begin
      fidx_r  <= '0;
      trunc_r <= 1'b0;
      for (int i = 0; i < MAX_FIELDS; i++) begin
        len_r[i] <= '0;
        for (int j = 0; j < FIELD_CHARS; j++) mem_r[i][j] <= 8'h00;
      end
    end else begin
      if (char_en) begin
        if (char_room_s) begin
          mem_r[fsel_s][cur_len_s[CW-1:0]] <= char_data;
          len_r[fsel_s]                    <= cur_len_s + LW'(1);
        end else begin
          trunc_r <= 1'b1;
        end
      end
      if (field_en) begin
        if (fidx_in_range_s) fidx_r <= fidx_r + NW'(1);
        // Opening field MAX_FIELDS+1 (or beyond) means fields are lost
        if (fidx_r >= NW'(MAX_FIELDS - 1)) trunc_r <= 1'b1;
      end
    end
  end

  for (genvar i = 0; i < MAX_FIELDS; i++) begin : g_field
    assign lens[i*LW +: LW] = len_r[i];
    for (genvar j = 0; j < FIELD_CHARS; j++) begin : g_char
      assign fields[(i*FIELD_CHARS+j)*8 +: 8] = mem_r[i][j];
    end
  end

  assign nfields = fidx_in_range_s ? (fidx_r + NW'(1)) : NW'(MAX_FIELDS);
  assign trunc   = trunc_r;

endmodule

// File: rtl/nmea_field_parser.sv
// NMEA-0183 sentence parser: filters on a sentence ID, splits comma fields into fixed
// ASCII slots, verifies the '*hh' XOR checksum and presents one record per sentence.
// Ports:
//  clk, rst        clock, asynchronous active-high reset
//  in_data/valid   received UART byte and its 1-cycle strobe (no backpressure)
//  out_fields      field i char j at [(i*FIELD_CHARS+j)*8 +: 8], unused chars 8'h00
//  out_len         stored chars per field
//  out_nfields     fields stored (saturates at MAX_FIELDS)
//  out_trunc       a field or the field count overflowed
//  out_csum_ok     '*hh' present and matching
//  out_valid/ready record handshake; record held stable until accepted
//  drop_pulse      1-cycle pulse when a finished record finds the output occupied
//  drop_cnt        saturating count of such drops
module nmea_field_parser
  import gps_pkg::*;
#(
  parameter int          MAX_FIELDS  = 8,
  parameter int          FIELD_CHARS = 12,
  parameter logic [23:0] SENTENCE_ID = 24'h474741,  // "GGA"
  parameter bit          CHECK_CSUM  = 1'b1,
  localparam int         LW          = $clog2(FIELD_CHARS + 1),
  localparam int         NW          = $clog2(MAX_FIELDS + 1)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [7:0]                          in_data,
  input  logic                                in_valid,
  output logic [MAX_FIELDS*FIELD_CHARS*8-1:0] out_fields,
  output logic [MAX_FIELDS*LW-1:0]            out_len,
  output logic [NW-1:0]                       out_nfields,
  output logic                                out_trunc,
  output logic                                out_csum_ok,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                drop_pulse,
  output logic [7:0]                          drop_cnt
);

  state_t      state_r, state_nxt;
  logic [2:0]  hdr_cnt_r;
  logic [23:0] hdr_id_r;     // last three header chars = sentence ID
  logic [7:0]  csum_r;
  logic [3:0]  nib_hi_r;
  logic        fin_ok_r;     // checksum present and matching
  logic        fin_bad_r;    // both digits received and mismatching

  logic        is_dollar_s, is_comma_s, is_star_s, is_eol_s;
  logic [4:0]  hex_s;
  logic        buf_clr_s, char_en_s, field_en_s;
  logic        deliver_s;

  logic [MAX_FIELDS*FIELD_CHARS*8-1:0] buf_fields_s;
  logic [MAX_FIELDS*LW-1:0]            buf_lens_s;
  logic [NW-1:0]                       buf_nfields_s;
  logic                                buf_trunc_s;

  // Byte classification
  always_comb begin
    is_dollar_s = (in_data == ASCII_DOLLAR);
    is_comma_s  = (in_data == ASCII_COMMA);
    is_star_s   = (in_data == ASCII_STAR);
    is_eol_s    = (in_data == ASCII_CR) || (in_data == ASCII_LF);
    hex_s       = hex_to_nib(in_data);
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_nxt;
  end

  // FSM next state; '$' restarts the header from any state
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid && is_dollar_s) state_nxt = ST_HDR;
        else                         state_nxt = ST_IDLE;
      end
      ST_HDR: begin
        if (!in_valid)                  state_nxt = ST_HDR;
        else if (is_dollar_s)           state_nxt = ST_HDR;
        else if (hdr_cnt_r < HDR_CHARS) begin
          if (is_comma_s || is_star_s || is_eol_s) state_nxt = ST_IDLE;
          else                                     state_nxt = ST_HDR;
        end else if (is_comma_s && (hdr_id_r == SENTENCE_ID)) state_nxt = ST_FLD;
        else                            state_nxt = ST_IDLE;
      end
      ST_FLD: begin
        if (!in_valid)        state_nxt = ST_FLD;
        else if (is_dollar_s) state_nxt = ST_HDR;
        else if (is_star_s)   state_nxt = ST_CS1;
        else if (is_eol_s)    state_nxt = ST_DONE;
        else                  state_nxt = ST_FLD;
      end
      ST_CS1: begin
        if (!in_valid)        state_nxt = ST_CS1;
        else if (is_dollar_s) state_nxt = ST_HDR;
        else if (hex_s[4])    state_nxt = ST_CS2;
        else                  state_nxt = ST_DONE;
      end
      ST_CS2: begin
        if (!in_valid)        state_nxt = ST_CS2;
        else if (is_dollar_s) state_nxt = ST_HDR;
        else                  state_nxt = ST_DONE;
      end
      ST_DONE: begin
        // DONE consumes no byte, but a '$' arriving now still starts a sentence
        if (in_valid && is_dollar_s) state_nxt = ST_HDR;
        else                         state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: working-buffer control and record hand-off decision
  always_comb begin
    buf_clr_s  = in_valid && is_dollar_s;
    char_en_s  = (state_r == ST_FLD) && in_valid &&
                 !is_dollar_s && !is_comma_s && !is_star_s && !is_eol_s;
    field_en_s = (state_r == ST_FLD) && in_valid && is_comma_s;
    deliver_s  = (state_r == ST_DONE) && !(CHECK_CSUM && fin_bad_r);
  end

  // Header capture, running checksum and checksum digit evaluation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hdr_cnt_r <= 3'd0;
      hdr_id_r  <= 24'd0;
      csum_r    <= 8'd0;
      nib_hi_r  <= 4'd0;
      fin_ok_r  <= 1'b0;
      fin_bad_r <= 1'b0;
    end else if (in_valid && is_dollar_s) begin
      hdr_cnt_r <= 3'd0;
      hdr_id_r  <= 24'd0;
      csum_r    <= 8'd0;
      nib_hi_r  <= 4'd0;
      fin_ok_r  <= 1'b0;
      fin_bad_r <= 1'b0;
    end else if (in_valid) begin
      case (state_r)
        ST_HDR: begin
          if (hdr_cnt_r < HDR_CHARS) begin
            hdr_cnt_r <= hdr_cnt_r + 3'd1;
            hdr_id_r  <= {hdr_id_r[15:0], in_data};
          end
          csum_r <= csum_r ^ in_data;
        end
        ST_FLD: begin
          if (!is_star_s && !is_eol_s) csum_r <= csum_r ^ in_data;
          if (is_eol_s) begin
            fin_ok_r  <= 1'b0;
            fin_bad_r <= 1'b0;
          end
        end
        ST_CS1: begin
          if (hex_s[4]) begin
            nib_hi_r <= hex_s[3:0];
          end else begin
            fin_ok_r  <= 1'b0;
            fin_bad_r <= 1'b0;
          end
        end
        ST_CS2: begin
          if (hex_s[4]) begin
            fin_ok_r  <= ({nib_hi_r, hex_s[3:0]} == csum_r);
            fin_bad_r <= ({nib_hi_r, hex_s[3:0]} != csum_r);
          end else begin
            fin_ok_r  <= 1'b0;
            fin_bad_r <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  nmea_field_buf #(
    .MAX_FIELDS (MAX_FIELDS),
    .FIELD_CHARS(FIELD_CHARS),
    .LW         (LW),
    .NW         (NW)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .clr      (buf_clr_s),
    .char_en  (char_en_s),
    .char_data(in_data),
    .field_en (field_en_s),
    .fields   (buf_fields_s),
    .lens     (buf_lens_s),
    .nfields  (buf_nfields_s),
    .trunc    (buf_trunc_s)
  );

  // Output record register and drop accounting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_fields  <= '0;
      out_len     <= '0;
      out_nfields <= '0;
      out_trunc   <= 1'b0;
      out_csum_ok <= 1'b0;
      out_valid   <= 1'b0;
      drop_pulse  <= 1'b0;
      drop_cnt    <= 8'd0;
    end else begin
      drop_pulse <= 1'b0;
      if (deliver_s) begin
        if (!out_valid || out_ready) begin
          out_fields  <= buf_fields_s;
          out_len     <= buf_lens_s;
          out_nfields <= buf_nfields_s;
          out_trunc   <= buf_trunc_s;
          out_csum_ok <= fin_ok_r;
          out_valid   <= 1'b1;
        end else begin
          drop_pulse <= 1'b1;
          if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_nmea_field_parser.sv
// Self-checking bench: two parser instances (checksum enforced / checksum only flagged) see
// the same byte stream. Sentences are built from a body string; a string-level model splits
// the body into fields and predicts each record, which a monitor compares on handshake.
module tb_nmea_field_parser;

  localparam int MF = 8;
  localparam int FC = 12;
  localparam int LW = 4;
  localparam int NW = 4;
  localparam int FB = MF * FC * 8;

  typedef struct packed {
    logic [FB-1:0]    fields;
    logic [MF*LW-1:0] lens;
    logic [NW-1:0]    nf;
    logic             trunc;
    logic             ok;
  } rec_t;

  logic clk = 1'b0;
  logic rst;
  logic [7:0] in_data;
  logic in_valid;
  logic out_ready;

  logic [FB-1:0] f1, f0;
  logic [MF*LW-1:0] l1, l0;
  logic [NW-1:0] n1, n0;
  logic t1, t0, c1, c0, v1, v0, dp1, dp0;
  logic [7:0] dc1, dc0;

  rec_t exp1[$];
  rec_t exp0[$];
  logic [7:0] body[$];
  int tests = 0;
  int fails = 0;
  int pulses1 = 0;
  int pulses0 = 0;
  int ready_mode = 1;   // 0 random, 1 hold low, 2 hold high
  int gap_max = 2;

  nmea_field_parser #(.MAX_FIELDS(8), .FIELD_CHARS(12), .SENTENCE_ID(24'h474741), .CHECK_CSUM(1'b1)) dut1 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .out_fields(f1), .out_len(l1), .out_nfields(n1), .out_trunc(t1), .out_csum_ok(c1),
    .out_valid(v1), .out_ready(out_ready), .drop_pulse(dp1), .drop_cnt(dc1));

  nmea_field_parser #(.MAX_FIELDS(8), .FIELD_CHARS(12), .SENTENCE_ID(24'h474741), .CHECK_CSUM(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .out_fields(f0), .out_len(l0), .out_nfields(n0), .out_trunc(t0), .out_csum_ok(c0),
    .out_valid(v0), .out_ready(out_ready), .drop_pulse(dp0), .drop_cnt(dc0));

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Consumer ready generator
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       out_ready = ($urandom_range(0, 3) != 0);
        2:       out_ready = 1'b1;
        default: out_ready = 1'b0;
      endcase
    end
  end

  task automatic check_out(input int which, input rec_t got);
    rec_t e;
    tests++;
    if ((which == 1 && exp1.size() == 0) || (which == 0 && exp0.size() == 0)) begin
      fails++;
      $display("FAIL rec_dut%0d: unexpected record nf=%0d ok=%b, required no record", which, got.nf, got.ok);
    end else begin
      if (which == 1) e = exp1.pop_front();
      else            e = exp0.pop_front();
      if (got !== e) begin
        fails++;
        $display("FAIL rec_dut%0d: got nf=%0d lens=%h trunc=%b ok=%b fields_eq=%0b, required nf=%0d lens=%h trunc=%b ok=%b",
                 which, got.nf, got.lens, got.trunc, got.ok, (got.fields === e.fields), e.nf, e.lens, e.trunc, e.ok);
      end
    end
  endtask

  // Monitor: compare every accepted record against the scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (dp1) pulses1++;
      if (dp0) pulses0++;
      if (v1 && out_ready) check_out(1, '{fields: f1, lens: l1, nf: n1, trunc: t1, ok: c1});
      if (v0 && out_ready) check_out(0, '{fields: f0, lens: l0, nf: n0, trunc: t0, ok: c0});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat ($urandom_range(0, gap_max)) tick();
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic set_body(input string s);
    body.delete();
    for (int i = 0; i < s.len(); i++) body.push_back(s[i]);
  endtask

  function automatic logic [7:0] hexc(input logic [3:0] n, input bit lower);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else if (lower) return 8'h61 + {4'h0, n} - 8'd10;
    else return 8'h41 + {4'h0, n} - 8'd10;
  endfunction

  // Reference model: split the body at commas and apply the slot limits
  task automatic model_push(input int mode);
    string flds[$];
    string cur;
    rec_t r;
    int n, len;
    if (!(body.size() >= 6 && body[2] == "G" && body[3] == "G" && body[4] == "A" && body[5] == ",")) return;
    cur = "";
    for (int k = 6; k < body.size(); k++) begin
      if (body[k] == ",") begin
        flds.push_back(cur);
        cur = "";
      end else begin
        cur = $sformatf("%s%c", cur, body[k]);
      end
    end
    flds.push_back(cur);
    r = '0;
    n = flds.size();
    r.nf = (n > MF) ? NW'(MF) : NW'(n);
    r.trunc = (n > MF);
    for (int i = 0; i < n; i++) begin
      if (flds[i].len() > FC) r.trunc = 1'b1;
      if (i < MF) begin
        len = (flds[i].len() > FC) ? FC : flds[i].len();
        r.lens[i*LW +: LW] = LW'(len);
        for (int j = 0; j < len; j++) r.fields[(i*FC+j)*8 +: 8] = flds[i][j];
      end
    end
    r.ok = (mode == 0);
    if (mode != 1) exp1.push_back(r);
    exp0.push_back(r);
  endtask

  // mode 0 good checksum, 1 wrong checksum, 2 no '*', 3 non-hex checksum digit
  task automatic send_sentence(input int mode, input bit expect_rec);
    logic [7:0] cs;
    bit lower;
    cs = 8'h00;
    foreach (body[k]) cs ^= body[k];
    if (expect_rec) model_push(mode);
    lower = $urandom_range(0, 1);
    send_byte("$");
    foreach (body[k]) send_byte(body[k]);
    case (mode)
      0: begin send_byte("*"); send_byte(hexc(cs[7:4], lower)); send_byte(hexc(cs[3:0], lower)); end
      1: begin
        cs = cs ^ 8'($urandom_range(1, 255));
        send_byte("*"); send_byte(hexc(cs[7:4], lower)); send_byte(hexc(cs[3:0], lower));
      end
      3: begin
        send_byte("*");
        if ($urandom_range(0, 1) == 0) send_byte("G");
        else begin send_byte(hexc(cs[7:4], lower)); send_byte("z"); end
      end
      default: ;
    endcase
    send_byte(8'h0D);
    send_byte(8'h0A);
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (!v1 && !v0) done = 1'b1;
    end
    if (!done) begin
      tests++; fails++;
      $display("FAIL wait_idle: out_valid still high after 400 cycles, required 0");
    end
    tick();
  endtask

  task automatic wait_valid();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (v1) done = 1'b1;
    end
    if (!done) begin
      tests++; fails++;
      $display("FAIL wait_valid: no out_valid within 400 cycles");
    end
  endtask

  task automatic check_zero(input string name);
    tests++;
    if ({f1, l1, n1, t1, c1, v1, dp1, dc1} != '0 || {f0, l0, n0, t0, c0, v0, dp0, dc0} != '0) begin
      fails++;
      $display("FAIL %s: got v=%b/%b nf=%0d/%0d drop_cnt=%0d/%0d, required all outputs 0", name, v1, v0, n1, n0, dc1, dc0);
    end
  endtask

  task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] req);
    tests++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  task automatic random_body();
    int nf, fl, c;
    body.delete();
    body.push_back("G");
    body.push_back(($urandom_range(0, 1) == 0) ? 8'h50 : 8'h4E);  // 'P' or 'N'
    if ($urandom_range(0, 3) != 0) begin body.push_back("G"); body.push_back("G"); body.push_back("A"); end
    else begin body.push_back("R"); body.push_back("M"); body.push_back("C"); end
    nf = $urandom_range(1, 10);
    for (int i = 0; i < nf; i++) begin
      body.push_back(",");
      fl = ($urandom_range(0, 4) == 0) ? $urandom_range(11, 15) : $urandom_range(0, 8);
      for (int j = 0; j < fl; j++) begin
        c = $urandom_range(0, 37);
        if (c < 10)       body.push_back(8'h30 + 8'(c));
        else if (c < 36)  body.push_back(8'h41 + 8'(c - 10));
        else if (c == 36) body.push_back(".");
        else              body.push_back("-");
      end
    end
  endtask

  initial begin
    logic [47:0] exp_f0;
    string s;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    ready_mode = 1;
    repeat (3) tick();
    check_zero("reset_state");
    rst = 1'b0;
    tick();

    // 1) reference GGA sentence, inspected while held
    gap_max = 0;
    set_body("GPGGA,123519,3130,N,12024,E");
    send_sentence(0, 1'b1);
    wait_valid();
    check_val("t1_nf_lens_ok_trunc", {n1, l1[19:0], c1, t1}, {4'd5, 4'd1, 4'd5, 4'd1, 4'd4, 4'd6, 1'b1, 1'b0});
    s = "123519";
    for (int j = 0; j < 6; j++) exp_f0[j*8 +: 8] = s[j];
    check_val("t1_field0", f1[47:0], exp_f0);
    ready_mode = 2;
    wait_idle();

    // 2) wrong checksum: suppressed with checking, flagged without
    gap_max = 1;
    send_sentence(1, 1'b1);
    wait_idle();
    check_val("t2_drop_cnt", dc1, 8'd0);

    // 3) other ID ignored; resync on a second '$'
    set_body("GPRMC,123,A");
    send_sentence(0, 1'b1);
    send_str("$GPGG");
    set_body("GPGGA,1");
    send_sentence(0, 1'b1);
    wait_idle();

    // 4) over-long field and too many fields
    ready_mode = 1;
    set_body("GPGGA,123456789ABCDEF,a,b,c,d,e,f,g,h,i");
    send_sentence(0, 1'b1);
    wait_valid();
    check_val("t4_nf_len0_trunc_ok", {n1, l1[3:0], t1, c1}, {4'd8, 4'd12, 1'b1, 1'b1});
    ready_mode = 2;
    wait_idle();

    // Randomised sentences with random consumer backpressure
    ready_mode = 0;
    gap_max = 2;
    for (int it = 0; it < 60; it++) begin
      wait_idle();
      repeat ($urandom_range(0, 3)) begin
        logic [7:0] junk;
        junk = 8'($urandom_range(0, 255));
        if (junk == 8'h24) junk = 8'h41;
        send_byte(junk);
      end
      random_body();
      send_sentence($urandom_range(0, 3), 1'b1);
    end
    ready_mode = 2;
    wait_idle();
    check_val("rand_no_drops", {dc1, dc0}, 16'h0000);

    // 5) second record while first is held -> dropped
    ready_mode = 1;
    set_body("GNGGA,111,22,3");
    send_sentence(0, 1'b1);
    wait_valid();
    set_body("GPGGA,999,88");
    send_sentence(0, 1'b0);
    repeat (4) tick();
    check_val("t5_held_valid", {v1, v0}, 2'b11);
    check_val("t5_drop_cnt", {dc1, dc0}, {8'd1, 8'd1});
    check_val("t5_drop_pulses", 64'(pulses1 * 16 + pulses0), 64'(17));
    ready_mode = 2;
    tick();
    ready_mode = 1;
    tick();
    tick();
    check_val("t5_valid_fall", {v1, v0}, 2'b00);

    // 6) reset mid-field, then a clean sentence
    ready_mode = 2;
    send_str("$GPGGA,12");
    rst = 1'b1;
    tick();
    check_zero("t6_in_reset");
    tick();
    rst = 1'b0;
    tick();
    set_body("GPGGA,77,X");
    send_sentence(0, 1'b1);
    wait_idle();
    repeat (20) tick();
    check_val("scoreboard_empty", 64'(exp1.size() * 256 + exp0.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
